// File: rtl/sa_pkg.sv
// Shared definitions for the systolic tile engine and its scheduler.
//   sa_state_e     : scheduler FSM states
//   sa_cmd_flags_t : per-tile command flags (weight reload, accumulate, last)
//   SA_T           : tile size in words (P*Q)
//   SA_AW/SA_TW    : command address width and tile-count field width
package sa_pkg;

    localparam int SA_P  = 8;
    localparam int SA_Q  = 8;
    localparam int SA_T  = SA_P * SA_Q;
    localparam int SA_AW = 32;
    localparam int SA_TW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sa_state_e;

    typedef struct packed {
        logic load_w;
        logic acc;
        logic last;
    } sa_cmd_flags_t;

endpackage

// File: rtl/sa_tile_addr_gen.sv
// Tile loop walker: n outer, k middle, m inner.
// Holds the m/k/n counters and running A/B/C pointers; all addresses come
// from adders, the only multiply is by the constant tile size T.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   init                latch config and rewind to m=k=n=0
//   adv                 step to the next tile (command handshake)
//   cfg_mt/kt/nt        tile counts (sampled on init)
//   cfg_a/b/c_base      base addresses (sampled on init)
//   a_addr/b_addr/c_addr current command addresses (registered)
//   flags               current command flags, flags.last marks the final tile
module sa_tile_addr_gen
    import sa_pkg::*;
#(
    parameter int AW = SA_AW,
    parameter int TW = SA_TW,
    parameter int T  = SA_T
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          adv,
    input  logic [TW-1:0] cfg_mt,
    input  logic [TW-1:0] cfg_kt,
    input  logic [TW-1:0] cfg_nt,
    input  logic [AW-1:0] cfg_a_base,
    input  logic [AW-1:0] cfg_b_base,
    input  logic [AW-1:0] cfg_c_base,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic [AW-1:0] c_addr,
    output sa_cmd_flags_t flags
);

    localparam logic [AW-1:0] TSZ = AW'(T);

    logic [TW-1:0] mt_q, kt_q, nt_q, m_q, k_q, n_q;
    logic [TW-1:0] mt_d, kt_d, nt_d, m_d, k_d, n_d;
    // a_k: A column start for current k (m=0); b_n/c_n: B/C start for current n
    logic [AW-1:0] a_base_q, a_k_q, b_n_q, c_n_q, stride_a_q, stride_n_q;
    logic [AW-1:0] a_base_d, a_k_d, b_n_d, c_n_d, stride_a_d, stride_n_d;
    logic [AW-1:0] a_q, b_q, c_q, a_d, b_d, c_d;
    sa_cmd_flags_t flags_q, flags_d;

    always_comb begin
        mt_d = mt_q; kt_d = kt_q; nt_d = nt_q;
        m_d  = m_q;  k_d  = k_q;  n_d  = n_q;
        a_base_d = a_base_q; a_k_d = a_k_q; b_n_d = b_n_q; c_n_d = c_n_q;
        stride_a_d = stride_a_q; stride_n_d = stride_n_q;
        a_d = a_q; b_d = b_q; c_d = c_q;
        flags_d = flags_q;

        if (init) begin
            mt_d = cfg_mt; kt_d = cfg_kt; nt_d = cfg_nt;
            m_d  = '0; k_d = '0; n_d = '0;
            a_base_d = cfg_a_base; a_k_d = cfg_a_base; a_d = cfg_a_base;
            b_n_d = cfg_b_base; b_d = cfg_b_base;
            c_n_d = cfg_c_base; c_d = cfg_c_base;
            // m step moves A by KT tiles; m step of C and k step of B move by NT tiles
            stride_a_d = AW'(cfg_kt) * TSZ;
            stride_n_d = AW'(cfg_nt) * TSZ;
        end else if (adv) begin
            if (m_q != mt_q - TW'(1)) begin
                m_d = m_q + TW'(1);
                a_d = a_q + stride_a_q;
                c_d = c_q + stride_n_q;
            end else begin
                m_d = '0;
                if (k_q != kt_q - TW'(1)) begin
                    k_d   = k_q + TW'(1);
                    a_k_d = a_k_q + TSZ;
                    a_d   = a_k_q + TSZ;
                    b_d   = b_q + stride_n_q;
                    c_d   = c_n_q;
                end else begin
                    k_d   = '0;
                    n_d   = n_q + TW'(1);
                    a_k_d = a_base_q;
                    a_d   = a_base_q;
                    b_n_d = b_n_q + TSZ;
                    b_d   = b_n_q + TSZ;
                    c_n_d = c_n_q + TSZ;
                    c_d   = c_n_q + TSZ;
                end
            end
        end

        // flags only move with the command so they read 0 out of reset
        if (init || adv) begin
            flags_d.load_w = (m_d == '0);
            flags_d.acc    = (k_d != '0);
            flags_d.last   = (m_d == mt_d - TW'(1)) && (k_d == kt_d - TW'(1)) &&
                             (n_d == nt_d - TW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_q <= '0; kt_q <= '0; nt_q <= '0;
            m_q  <= '0; k_q  <= '0; n_q  <= '0;
            a_base_q <= '0; a_k_q <= '0; b_n_q <= '0; c_n_q <= '0;
            stride_a_q <= '0; stride_n_q <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0;
            flags_q <= '0;
        end else begin
            mt_q <= mt_d; kt_q <= kt_d; nt_q <= nt_d;
            m_q  <= m_d;  k_q  <= k_d;  n_q  <= n_d;
            a_base_q <= a_base_d; a_k_q <= a_k_d; b_n_q <= b_n_d; c_n_q <= c_n_d;
            stride_a_q <= stride_a_d; stride_n_q <= stride_n_d;
            a_q <= a_d; b_q <= b_d; c_q <= c_d;
            flags_q <= flags_d;
        end
    end

    assign a_addr = a_q;
    assign b_addr = b_q;
    assign c_addr = c_q;
    assign flags  = flags_q;

endmodule

// File: rtl/sa_tile_scheduler.sv
// GEMM tile scheduler for the weight-stationary systolic engine.
// Walks the tile loop nest, issues one command per tile to the front end,
// and tracks tiles in flight until the engine reports them complete.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      job start pulse (honoured only in IDLE)
//   cfg_mt/kt/nt               tile counts; any zero flags err and skips the job
//   cfg_a/b/c_base             base addresses (word addressed)
//   busy, done, err            job status; err is sticky until the next start
//   cmd_valid/cmd_ready        command handshake
//   cmd_a/b/c_addr             tile addresses
//   cmd_load_w/cmd_acc/cmd_last command flags
//   tile_done                  engine completion pulse, one per tile
// Build option SA_SCHED_PERF_EN adds perf_cycles and perf_stall counters.
module sa_tile_scheduler
    import sa_pkg::*;
#(
    parameter int P        = SA_P,
    parameter int Q        = SA_Q,
    parameter int AW       = SA_AW,
    parameter int TW       = SA_TW,
    parameter int MAX_OUTS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [TW-1:0] cfg_mt,
    input  logic [TW-1:0] cfg_kt,
    input  logic [TW-1:0] cfg_nt,
    input  logic [AW-1:0] cfg_a_base,
    input  logic [AW-1:0] cfg_b_base,
    input  logic [AW-1:0] cfg_c_base,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [AW-1:0] cmd_a_addr,
    output logic [AW-1:0] cmd_b_addr,
    output logic [AW-1:0] cmd_c_addr,
    output logic          cmd_load_w,
    output logic          cmd_acc,
    output logic          cmd_last,
    input  logic          tile_done
`ifdef SA_SCHED_PERF_EN
    ,
    output logic [31:0]   perf_cycles,
    output logic [31:0]   perf_stall
`endif
);

    localparam int T  = P * Q;
    localparam int OW = $clog2(MAX_OUTS + 1);
    localparam logic [OW-1:0] OUTS_MAX = OW'(MAX_OUTS);

    sa_state_e     state_q, state_d;
    logic [OW-1:0] outs_q, outs_d;
    logic          err_d;
    logic          hs, go, cfg_zero, td_ok, td_bad, init;
    sa_cmd_flags_t flags;

    assign hs       = cmd_valid && cmd_ready;
    assign go       = (state_q == IDLE) && start;
    assign cfg_zero = (cfg_mt == '0) || (cfg_kt == '0) || (cfg_nt == '0);
    assign init     = go && !cfg_zero;
    // a completion is only legal while a job has tiles in flight
    assign td_ok    = tile_done && (state_q != IDLE) && (outs_q != '0);
    assign td_bad   = tile_done && !td_ok;

    sa_tile_addr_gen #(.AW(AW), .TW(TW), .T(T)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .adv        (hs),
        .cfg_mt     (cfg_mt),
        .cfg_kt     (cfg_kt),
        .cfg_nt     (cfg_nt),
        .cfg_a_base (cfg_a_base),
        .cfg_b_base (cfg_b_base),
        .cfg_c_base (cfg_c_base),
        .a_addr     (cmd_a_addr),
        .b_addr     (cmd_b_addr),
        .c_addr     (cmd_c_addr),
        .flags      (flags)
    );

    assign cmd_load_w = flags.load_w;
    assign cmd_acc    = flags.acc;
    assign cmd_last   = flags.last;

    always_comb begin
        outs_d = outs_q;
        case ({hs, td_ok})
            2'b10:   outs_d = outs_q + OW'(1);
            2'b01:   outs_d = outs_q - OW'(1);
            default: outs_d = outs_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_d   = err;
        case (state_q)
            IDLE: if (start) begin
                // a degenerate job passes through an empty DRAIN so done
                // lands two cycles after start with no command issued
                state_d = cfg_zero ? DRAIN : ISSUE;
                err_d   = cfg_zero;
            end
            ISSUE: if (hs && cmd_last) state_d = DRAIN;
            DRAIN: if (outs_d == '0)   state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (td_bad) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            outs_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cmd_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            outs_q    <= outs_d;
            busy      <= (state_d == ISSUE) || (state_d == DRAIN);
            done      <= (state_d == DONE);
            err       <= err_d;
            // throttled while the in-flight window is full
            cmd_valid <= (state_d == ISSUE) && (outs_d != OUTS_MAX);
        end
    end

`ifdef SA_SCHED_PERF_EN
    logic stall;
    assign stall = (cmd_valid && !cmd_ready) || ((state_q == ISSUE) && (outs_q == OUTS_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (go) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && (perf_cycles != '1))  perf_cycles <= perf_cycles + 32'd1;
            if (stall && (perf_stall != '1))  perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Directed bench for sa_tile_scheduler (P=Q=8, so T=64 words per tile).
module tb_sa_tile_scheduler;
    import sa_pkg::*;

    localparam int AW = 32;
    localparam int TW = 8;
    localparam int TT = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [TW-1:0] cfg_mt = '0, cfg_kt = '0, cfg_nt = '0;
    logic [AW-1:0] cfg_a_base = '0, cfg_b_base = '0, cfg_c_base = '0;
    logic          busy, done, err, cmd_valid;
    logic          cmd_ready = 1'b0;
    logic [AW-1:0] cmd_a_addr, cmd_b_addr, cmd_c_addr;
    logic          cmd_load_w, cmd_acc, cmd_last;
    logic          tile_done = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sa_tile_scheduler #(.P(8), .Q(8), .AW(AW), .TW(TW), .MAX_OUTS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_mt(cfg_mt), .cfg_kt(cfg_kt), .cfg_nt(cfg_nt),
        .cfg_a_base(cfg_a_base), .cfg_b_base(cfg_b_base), .cfg_c_base(cfg_c_base),
        .busy(busy), .done(done), .err(err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr), .cmd_c_addr(cmd_c_addr),
        .cmd_load_w(cmd_load_w), .cmd_acc(cmd_acc), .cmd_last(cmd_last),
        .tile_done(tile_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {busy, done, err, cmd_valid, cmd_load_w, cmd_acc, cmd_last} |
               64'(cmd_a_addr) | 64'(cmd_b_addr) | 64'(cmd_c_addr);
    endfunction

    // returns at the negedge after the start edge, start already low
    task automatic do_start(input int mt, input int kt, input int nt,
                            input int ab, input int bb, input int cb);
        @(negedge clk);
        cfg_mt = TW'(mt); cfg_kt = TW'(kt); cfg_nt = TW'(nt);
        cfg_a_base = AW'(ab); cfg_b_base = AW'(bb); cfg_c_base = AW'(cb);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // full job with echoed completions; checks every command against the
    // nested-loop formula, stability under backpressure, count and done timing
    task automatic run_job(input string nm, input int mt, input int kt, input int nt,
                           input int ab, input int bb, input int cb, input bit rnd);
        int idx = 0, pend = 0, cyc = 0, td_cyc = -10, done_cyc = -1;
        int m, k, n;
        bit stalled = 0;
        logic [AW*3+2:0] held = '0;
        do_start(mt, kt, nt, ab, bb, cb);
        check({nm, "_busy"}, busy, 1);
        check({nm, "_err_clr"}, err, 0);
        check({nm, "_valid0"}, cmd_valid, 1);
        while (done_cyc < 0 && cyc < 2000) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (stalled && cmd_valid)
                    check({nm, "_stable"}, {cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_load_w, cmd_acc, cmd_last}, held);
                tile_done = (pend > 0);
                if (pend > 0) begin pend--; td_cyc = cyc; end
                cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (cmd_valid && cmd_ready) begin
                    n = idx / (mt * kt);
                    k = (idx / mt) % kt;
                    m = idx % mt;
                    check({nm, "_a"}, cmd_a_addr, AW'(ab + (m * kt + k) * TT));
                    check({nm, "_b"}, cmd_b_addr, AW'(bb + (k * nt + n) * TT));
                    check({nm, "_c"}, cmd_c_addr, AW'(cb + (m * nt + n) * TT));
                    check({nm, "_flags"}, {cmd_load_w, cmd_acc, cmd_last},
                          {m == 0, k != 0, idx == mt * kt * nt - 1});
                    idx++; pend++; stalled = 0;
                end else if (cmd_valid) begin
                    stalled = 1;
                    held = {cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_load_w, cmd_acc, cmd_last};
                end else begin
                    stalled = 0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        tile_done = 1'b0;
        cmd_ready = 1'b0;
        check({nm, "_timeout"}, done_cyc >= 0, 1);
        check({nm, "_count"}, idx, mt * kt * nt);
        check({nm, "_done_lat"}, done_cyc, td_cyc + 1);
        check({nm, "_end_busy"}, busy, 0);
        @(negedge clk);
        check({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int hs, pend, cyc;

        // reset state
        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), 0);

        // 1: single tile
        run_job("t1", 1, 1, 1, 0, 100, 200, 0);

        // 2: 2x2x2 at full rate
        run_job("t2", 2, 2, 2, 1000, 2000, 3000, 0);

        // 3: same with random backpressure
        run_job("t3", 2, 2, 2, 1000, 2000, 3000, 1);

        // 4: window limit, start while busy ignored
        do_start(2, 2, 2, 1000, 2000, 3000);
        cmd_ready = 1'b1;
        hs = 0;
        repeat (10) begin
            if (cmd_valid) hs++;
            @(negedge clk);
        end
        check("t4_window", hs, 4);
        check("t4_valid_low", cmd_valid, 0);
        cfg_mt = 8'd1; cfg_a_base = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_busy_start", {busy, cmd_valid}, 2'b10);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        check("t4_valid_rise", cmd_valid, 1);
        check("t4_cmd5_addr", {cmd_a_addr, cmd_b_addr, cmd_c_addr}, {32'd1000, 32'd2064, 32'd3064});
        hs = 0;
        repeat (6) begin
            if (cmd_valid) hs++;
            @(negedge clk);
        end
        check("t4_one_more", hs, 1);
        pend = 4;
        cyc = 0;
        while (!done && cyc < 200) begin
            tile_done = (pend > 0);
            if (pend > 0) pend--;
            if (cmd_valid) begin hs++; pend++; end
            @(negedge clk);
            cyc++;
        end
        tile_done = 1'b0;
        check("t4_done", done, 1);
        check("t4_total", hs, 4);
        check("t4_err", err, 0);
        @(negedge clk);

        // 5: zero tile count
        do_start(2, 0, 2, 0, 0, 0);
        check("t5_st1", {busy, done, err, cmd_valid}, 4'b1010);
        @(negedge clk);
        check("t5_st2", {busy, done, err, cmd_valid}, 4'b0110);
        @(negedge clk);
        check("t5_st3", {busy, done, err, cmd_valid}, 4'b0010);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        check("t5_spurious", err, 1);

        // err clears on a good start, then a spurious completion sets it
        run_job("t5b", 1, 1, 1, 0, 100, 200, 0);
        tile_done = 1'b1;
        @(negedge clk);
        tile_done = 1'b0;
        check("t5_idle_td", err, 1);

        // 6: reset mid-job, then restart from the first tile
        do_start(2, 2, 2, 1000, 2000, 3000);
        cmd_ready = 1'b1;
        hs = 0;
        cyc = 0;
        while (hs < 3 && cyc < 20) begin
            if (cmd_valid) hs++;
            @(negedge clk);
            cyc++;
        end
        cmd_ready = 1'b0;
        check("t6_three", hs, 3);
        rst_n = 1'b0;
        #1;
        check("t6_reset_outs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_after_rst", all_outs(), 0);
        run_job("t6", 2, 2, 2, 1000, 2000, 3000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
